// File: rtl/pcm_sample_fifo.sv
// Parametrised PCM sample FIFO with occupancy count, level thresholds and sticky error flags.
// Define PCM_FIFO_EDGE_EN to turn wr/rd into falling-edge-detected strobes.
module pcm_sample_fifo #(
  parameter int DBITS    = 16,
  parameter int ABITS    = 4,
  parameter int AF_LEVEL = 2**ABITS - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_wr,
  input  logic [DBITS-1:0] i_din,
  input  logic             i_rd,
  input  logic             i_clr_err,
  output logic [DBITS-1:0] o_dout,
  output logic             o_dout_valid,
  output logic [ABITS:0]   o_count,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_almost_full,
  output logic             o_almost_empty,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam int             DEPTH   = 2**ABITS;
  localparam logic [ABITS:0] C_ZERO  = (ABITS+1)'(0);
  localparam logic [ABITS:0] C_DEPTH = (ABITS+1)'(DEPTH);
  localparam logic [ABITS:0] C_AF    = (ABITS+1)'(AF_LEVEL);
  localparam logic [ABITS:0] C_AE    = (ABITS+1)'(AE_LEVEL);

  logic [DBITS-1:0] r_mem [DEPTH];
  logic [ABITS-1:0] r_wr_ptr;
  logic [ABITS-1:0] r_rd_ptr;
  logic [ABITS:0]   r_count;
  logic [DBITS-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic w_wr_p;
  logic w_rd_p;
  logic w_empty;
  logic w_full;
  logic w_rd_acc;
  logic w_wr_acc;

`ifdef PCM_FIFO_EDGE_EN
  logic r_wr_s1;
  logic r_wr_s2;
  logic r_rd_s1;
  logic r_rd_s2;

  // Two-flop chains; resetting to 0 means no pulse can appear on reset release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_s1 <= 1'b0;
      r_wr_s2 <= 1'b0;
      r_rd_s1 <= 1'b0;
      r_rd_s2 <= 1'b0;
    end else begin
      r_wr_s1 <= i_wr;
      r_wr_s2 <= r_wr_s1;
      r_rd_s1 <= i_rd;
      r_rd_s2 <= r_rd_s1;
    end
  end

  assign w_wr_p = ~r_wr_s1 & r_wr_s2;
  assign w_rd_p = ~r_rd_s1 & r_rd_s2;
`else
  assign w_wr_p = i_wr;
  assign w_rd_p = i_rd;
`endif

  assign w_empty  = (r_count == C_ZERO);
  assign w_full   = (r_count == C_DEPTH);
  // A read frees a slot in the same cycle, so a write while full still lands.
  assign w_rd_acc = w_rd_p & ~w_empty;
  assign w_wr_acc = w_wr_p & (~w_full | w_rd_acc);

  // Storage is not reset; pointers and count alone define valid contents.
  always_ff @(posedge clock) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= {ABITS{1'b0}};
      r_rd_ptr     <= {ABITS{1'b0}};
      r_count      <= C_ZERO;
      r_dout       <= {DBITS{1'b0}};
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_dout_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_dout   <= r_mem[r_rd_ptr];
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A new error in the same cycle as clr_err keeps the flag set.
      if (w_wr_p & ~w_wr_acc) begin
        r_overflow <= 1'b1;
      end else if (i_clr_err) begin
        r_overflow <= 1'b0;
      end
      if (w_rd_p & w_empty) begin
        r_underflow <= 1'b1;
      end else if (i_clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign o_dout         = r_dout;
  assign o_dout_valid   = r_dout_valid;
  assign o_count        = r_count;
  assign o_empty        = w_empty;
  assign o_full         = w_full;
  assign o_almost_full  = (r_count >= C_AF);
  assign o_almost_empty = (r_count <= C_AE);
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_pcm_sample_fifo.sv
// Directed bench for pcm_sample_fifo (depth 4); the edge-strobe sequence runs when PCM_FIFO_EDGE_EN is defined.
module tb_pcm_sample_fifo;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr = 1'b0;
  logic [15:0] din = 16'h0000;
  logic        rd = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic [2:0]  count;
  logic        empty, full, almost_full, almost_empty, overflow, underflow;

  int total = 0;
  int bad   = 0;

  pcm_sample_fifo #(.DBITS(16), .ABITS(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clock(clock), .reset(reset), .i_wr(wr), .i_din(din), .i_rd(rd), .i_clr_err(clr_err),
    .o_dout(dout), .o_dout_valid(dout_valid), .o_count(count), .o_empty(empty), .o_full(full),
    .o_almost_full(almost_full), .o_almost_empty(almost_empty),
    .o_overflow(overflow), .o_underflow(underflow)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [2:0] c, input logic e, input logic f,
                           input logic af, input logic ae);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".empty"}, 32'(empty), 32'(e));
    chk({tag, ".full"}, 32'(full), 32'(f));
    chk({tag, ".afull"}, 32'(almost_full), 32'(af));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(ae));
  endtask

  task automatic chk_read(input string tag, input logic [15:0] d, input logic v);
    chk({tag, ".dout"}, 32'(dout), 32'(d));
    chk({tag, ".dv"}, 32'(dout_valid), 32'(v));
  endtask

  initial begin
    cyc(); cyc();
    reset = 1'b0;
    cyc(); cyc();
    chk_flags("rst", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_read("rst", 16'h0000, 1'b0);
    chk("rst.ovf", 32'(overflow), 32'd0);
    chk("rst.udf", 32'(underflow), 32'd0);

`ifdef PCM_FIFO_EDGE_EN
    // wr high 5 cycles, then low: one write two edges after the fall
    wr = 1'b1; din = 16'hBEEF;
    repeat (5) cyc();
    chk("e.hold", 32'(count), 32'd0);
    wr = 1'b0;
    cyc();
    chk("e.n1", 32'(count), 32'd0);
    cyc();
    chk_flags("e.n2", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    chk("e.single", 32'(count), 32'd1);
    rd = 1'b1;
    cyc(); chk_read("e.rdh1", 16'h0000, 1'b0);
    cyc(); chk_read("e.rdh2", 16'h0000, 1'b0);
    cyc(); chk_read("e.rdh3", 16'h0000, 1'b0);
    chk("e.rdh.count", 32'(count), 32'd1);
    rd = 1'b0;
    cyc(); chk_read("e.rdn1", 16'h0000, 1'b0);
    cyc(); chk_read("e.rdn2", 16'hBEEF, 1'b1);
    chk_flags("e.rdn2", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(); chk_read("e.rdn3", 16'hBEEF, 1'b0);
    chk("e.udf", 32'(underflow), 32'd0);
`else
    // fill to full
    wr = 1'b1;
    din = 16'h1111; cyc(); chk_flags("w1", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    din = 16'h2222; cyc(); chk_flags("w2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    din = 16'h3333; cyc(); chk_flags("w3", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    din = 16'h4444; cyc(); chk_flags("w4", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    din = 16'h5555; cyc(); chk_flags("w5", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("w5.ovf", 32'(overflow), 32'd1);
    wr = 1'b0;
    // drain, then one read too many
    rd = 1'b1;
    cyc(); chk_read("r1", 16'h1111, 1'b1); chk("r1.count", 32'(count), 32'd3);
    cyc(); chk_read("r2", 16'h2222, 1'b1); chk("r2.count", 32'(count), 32'd2);
    cyc(); chk_read("r3", 16'h3333, 1'b1); chk_flags("r3", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(); chk_read("r4", 16'h4444, 1'b1); chk_flags("r4", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(); chk_read("r5", 16'h4444, 1'b0);
    chk("r5.udf", 32'(underflow), 32'd1);
    chk("r5.ovf", 32'(overflow), 32'd1);
    rd = 1'b0; clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    chk("clr1.ovf", 32'(overflow), 32'd0);
    chk("clr1.udf", 32'(underflow), 32'd0);

    // wrap-around
    wr = 1'b1;
    for (int i = 1; i <= 3; i++) begin din = 16'(i); cyc(); end
    wr = 1'b0; rd = 1'b1;
    cyc(); chk_read("wp.r1", 16'h0001, 1'b1);
    cyc(); chk_read("wp.r2", 16'h0002, 1'b1);
    cyc(); chk_read("wp.r3", 16'h0003, 1'b1);
    rd = 1'b0; wr = 1'b1;
    din = 16'hA000; cyc();
    din = 16'hA001; cyc();
    din = 16'hA002; cyc();
    din = 16'hA003; cyc();
    chk_flags("wp.full", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("wp.ovf", 32'(overflow), 32'd0);

    // simultaneous read and write while full
    rd = 1'b1; din = 16'hB000;
    cyc(); chk_read("sf", 16'hA000, 1'b1);
    chk("sf.count", 32'(count), 32'd4);
    chk("sf.ovf", 32'(overflow), 32'd0);
    wr = 1'b0;
    cyc(); chk_read("sf.r1", 16'hA001, 1'b1);
    cyc(); chk_read("sf.r2", 16'hA002, 1'b1);
    cyc(); chk_read("sf.r3", 16'hA003, 1'b1);
    cyc(); chk_read("sf.r4", 16'hB000, 1'b1);
    chk("sf.empty", 32'(empty), 32'd1);

    // simultaneous read and write while empty
    wr = 1'b1; rd = 1'b1; din = 16'hC000;
    cyc();
    chk_read("se", 16'hB000, 1'b0);
    chk("se.count", 32'(count), 32'd1);
    chk("se.udf", 32'(underflow), 32'd1);
    chk("se.ovf", 32'(overflow), 32'd0);
    wr = 1'b0;
    cyc(); chk_read("se.r", 16'hC000, 1'b1);
    // clear in the same cycle as a new underflow: set wins
    clr_err = 1'b1;
    cyc(); chk("setwin.udf", 32'(underflow), 32'd1);
    rd = 1'b0;
    cyc(); chk("clr2.udf", 32'(underflow), 32'd0);
    clr_err = 1'b0;

    // asynchronous reset mid-operation
    wr = 1'b1; din = 16'hD000;
    cyc(); cyc();
    wr = 1'b0;
    chk("pre.count", 32'(count), 32'd2);
    reset = 1'b1;
    #1;
    chk_flags("arst", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("arst.dout", 32'(dout), 32'd0);
    cyc();
    reset = 1'b0;
    rd = 1'b1;
    cyc();
    chk_read("arst.rd", 16'h0000, 1'b0);
    chk("arst.udf", 32'(underflow), 32'd1);
    rd = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcm_sample_fifo.md
# pcm_sample_fifo

Parametrised synchronous FIFO that buffers PCM microphone samples between the capture front-end and the audio consumer, such as the processing or playback path. It generalises the single-bit, button-driven buffer: configurable width and depth, every entry usable, an occupancy count, almost-full and almost-empty thresholds, a read-valid strobe and sticky overflow/underflow flags. Strobe edge detection is a compile-time option.

## Interface
Parameters:
- DBITS, 16, sample width in bits
- ABITS, 4, address bits; depth = 2**ABITS, all entries usable
- AF_LEVEL, 2**ABITS-2, almost_full asserted when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- wr  in  1  write request
- din  in  DBITS  write data
- rd  in  1  read request
- clr_err  in  1  synchronous clear of overflow/underflow
- dout  out  DBITS  read data, registered
- dout_valid  out  1  one-cycle pulse, dout updated this cycle
- count  out  ABITS+1  occupancy, 0..2**ABITS
- empty  out  1  count == 0
- full  out  1  count == 2**ABITS
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- overflow  out  1  sticky, write attempted while full and no read accepted
- underflow  out  1  sticky, read attempted while empty

## Operation
- The internal write and read strobes are wr_p and rd_p. See Configuration for how they are derived.
- Storage is a 2**ABITS x DBITS array. The wr_ptr and rd_ptr pointers are ABITS wide and wrap modulo 2**ABITS.
- count is a separate ABITS+1-bit counter. full and empty are decoded from count, never from pointer equality.
- Accept rules, evaluated every cycle on current state:
  - rd_acc = rd_p & ~empty
  - wr_acc = wr_p & (~full | rd_acc)
- A simultaneous write and read while full are both accepted; count is unchanged.
- A simultaneous write and read while empty: only the write is accepted and underflow is set.
- wr_acc: mem[wr_ptr] <= din; wr_ptr increments.
- rd_acc: dout <= mem[rd_ptr]; rd_ptr increments; dout_valid = 1 next cycle.
- count update: +1 when only wr_acc, -1 when only rd_acc, otherwise unchanged.
- overflow is set when wr_p & ~wr_acc. underflow is set when rd_p & empty.
- Both flags hold until clr_err or reset. If clr_err and a new error occur in the same cycle, the set wins.
- dout holds its last value when no read is accepted.
- No state machine beyond the pointers, counter and flags. Flags are combinational decodes of the registered count.

## Timing
- Reset (async assert, sync release internally not required):
  - pointers, count, dout, dout_valid, overflow, underflow = 0
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0
- Write commit: rising edge where wr_p = 1. count, empty and full reflect the write immediately after that edge.
- Read latency: dout and dout_valid are valid 1 cycle after the edge where rd_acc occurs.
- Back-to-back: one read and one write per cycle maximum, sustained.
- Wrap-around: pointers roll from 2**ABITS-1 to 0 without any bubble.
- Reset mid-operation: all contents are discarded; the state is identical to power-on reset.

## Configuration
- PCM_FIFO_EDGE_EN defined:
  - Each of wr and rd passes through a 2-flop chain (s1, s2); the strobe is ~s1 & s2, one pulse per falling edge (1->0) of the input.
  - Input low sampled at edge N gives a commit at edge N+1.
  - din must remain stable through edge N+1.
  - The chain flops reset to 0, so no spurious pulse is produced on reset release.
- Not defined:
  - wr_p = wr and rd_p = rd, level-sensitive. Every cycle the input is high is a separate request.
  - No added latency.

## Test plan
Use DBITS=16, ABITS=2 (depth 4), AF_LEVEL=3, AE_LEVEL=1, macro undefined unless stated.
- Reset, then idle:
  - empty=1, almost_empty=1, count=0, dout=0, all other flags 0.
- Write 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles:
  - count 1, 2, 3, 4; almost_full at count=3; full at 4.
  - A 5th write of 0x5555 sets overflow, count stays 4, and the stored data is unchanged.
- From full, read 4 times:
  - dout 0x1111..0x4444, each with a dout_valid pulse 1 cycle after its read; empty=1 after the 4th.
  - A 5th read sets underflow, with no dout_valid and dout held at 0x4444.
- Wrap-around:
  - Write 3 words, read 3, then write 4 words 0xA000..0xA003.
  - Reading 4 returns 0xA000..0xA003 in order.
- Simultaneous read and write:
  - When full: both accepted, count stays 4, no overflow.
  - When empty: write accepted, count=1, underflow=1.
  - clr_err clears both flags.
- PCM_FIFO_EDGE_EN defined:
  - wr held high for 5 cycles then low with din=0xBEEF: exactly one write, committed 2 edges after wr goes low, count=1.
  - rd held high for 3 cycles: no read until its falling edge; then one read with dout=0xBEEF.
